seq_shift_add_multiplier: RTL and testbench

- Multi-cycle unsigned 64x64 multiplier for the ALU's MUL path; returns the low 64 bits of the product.
- Sits beside the datapath's 64-bit ripple adder.
  - Upstream role: drives the adder's two operand inputs each iteration.
  - Downstream role: consumes the adder's sum as the new partial product.
- One add-and-shift iteration per clock; start/busy/done handshake to the control unit.

---
 rtl/seq_shift_add_multiplier.sv | 103 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential shift-and-add 64x64 multiplier (low half), drives external adder
// Optional: define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] add_in1,
  output logic [WIDTH-1:0] add_in2,
  input  logic [WIDTH-1:0] add_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic             in_run;

  // Adder operands are held at zero outside RUN so the shared adder sees no activity.
  assign in_run  = (state == RUN);
  assign add_in1 = in_run ? acc : '0;
  assign add_in2 = (in_run && mplier[0]) ? mcand : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef SEQ_MUL_EARLY_EXIT_EN
          if (mplier == '0) begin
            product <= acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          begin
            acc    <= add_out;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (count == LAST) begin
              product <= add_out;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - directed-vector bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic [63:0] add_in1;
  logic [63:0] add_in2;
  logic [63:0] add_out;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Environment adder: 64-bit sum, carry-out dropped.
  assign add_out = add_in1 + add_in2;

  seq_shift_add_multiplier #(.WIDTH(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .busy(busy), .done(done), .product(product)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    int          lat_ee;
  } vec_t;

  vec_t vecs[7];

  function automatic int lat_of(input int lat_ee);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    return lat_ee;
`else
    return 64;
`endif
  endfunction

  task automatic run_op(input string tag, input vec_t v);
    int n;
    int busy_cnt;
    multiplicand = v.a;
    multiplier   = v.b;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " add_in1"}, add_in1, 64'd0);
    check({tag, " add_in2"}, add_in2, v.b[0] ? v.a : 64'd0);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat_of(v.lat_ee)));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat_of(v.lat_ee)));
    check({tag, " product"}, product, v.p);
    @(posedge clk); #1;
    check({tag, " done drop"}, 64'(done), 64'd0);
    check({tag, " busy after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic [63:0] got;

    vecs[0] = '{64'd3, 64'd5, 64'd15, 4};
    vecs[1] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, 3};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
    vecs[3] = '{64'd1008, 64'd1, 64'd1008, 2};
    vecs[4] = '{64'd1234, 64'd0, 64'd0, 1};
    vecs[5] = '{64'd12, 64'd4, 64'd48, 4};
    vecs[6] = '{64'h1_2345_6789, 64'h10, 64'h12_3456_7890, 6};

    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    check("reset add_in1", add_in1, 64'd0);
    check("reset add_in2", add_in2, 64'd0);

    // Reset has priority over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    multiplicand = 64'd3;
    multiplier   = 64'd5;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("reset+start busy", 64'(busy), 64'd0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // start during RUN must not re-latch operands or spawn a second result.
    multiplicand = 64'd7;
    multiplier   = 64'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = 64'd100;
    multiplier   = 64'd100;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    ndone = 0;
    got = '0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        ndone++;
        got = product;
      end
    end
    check("busy-start done count", 64'(ndone), 64'd1);
    check("busy-start product", got, 64'd63);

    // Back-to-back: start held high through DONE.
    multiplicand = 64'd12;
    multiplier   = 64'd4;
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = 64'd1000;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b first latency", 64'(n), 64'(lat_of(4)));
    check("b2b first product", product, 64'd48);
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    check("b2b restart busy", 64'(busy), 64'd1);
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b second latency", 64'(n), 64'(2 * lat_of(4) + 1));
    check("b2b second product", product, 64'd4000);

    // Reset mid-operation: no done pulse, product cleared.
    multiplicand = 64'd1004;
    multiplier   = 64'd4;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    repeat (1) @(posedge clk);
`else
    repeat (29) @(posedge clk);
`endif
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset product", product, 64'd0);
    ndone = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midreset no done", 64'(ndone), 64'd0);
    check("midreset product held", product, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
